// File: rtl/fetch_sequencer_if.sv
// Instruction issue bus from the fetch sequencer to decode/execute.
// The master drives the assembled instruction and valid; the slave returns ready.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_W-1:0]     opcode;
   logic [2*DATA_W-1:0]   operand;
   logic [1:0]            instr_len;
   logic [ADDR_W-1:0]     instr_pc;

   modport master (
      output instr_valid,
      output opcode,
      output operand,
      output instr_len,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  opcode,
      input  operand,
      input  instr_len,
      input  instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Variable-length (1-3 byte) instruction fetch controller with jump handling.
// Optional macro FETCH_PERF_EN adds a saturating issued-instruction counter port.
module fetch_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_count,
   output logic              pc_increment,
   output logic              pc_set,
   output logic [ADDR_W-1:0] pc_new_count,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              halt,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              jump_ack,
   fetch_sequencer_if.master issue
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       instr_count
`endif
);

   typedef enum logic [2:0] {
      REQ_OP = 3'd0,
      CAP_OP = 3'd1,
      CAP_LO = 3'd2,
      CAP_HI = 3'd3,
      ISSUE  = 3'd4
   } state_t;

   state_t                state_r;
   state_t                next_state_s;
   logic [DATA_W-1:0]     opcode_r;
   logic [2*DATA_W-1:0]   operand_r;
   logic [1:0]            len_r;
   logic [ADDR_W-1:0]     instr_pc_r;
   logic                  valid_s;
   logic [1:0]            op_len_s;

   // Instruction length from the two opcode MSBs: 00 -> 1, 01 -> 2, 1x -> 3.
   function automatic logic [1:0] decode_len(input logic [DATA_W-1:0] op);
      logic [1:0] len;
      case (op[DATA_W-1 -: 2])
         2'b00:   len = 2'd1;
         2'b01:   len = 2'd2;
         default: len = 2'd3;
      endcase
      return len;
   endfunction

   assign op_len_s = decode_len(mem_data);

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= REQ_OP;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a jump restarts fetch at an instruction boundary.
   always_comb begin
      next_state_s = state_r;
      if (jump_req) begin
         next_state_s = REQ_OP;
      end else begin
         case (state_r)
            REQ_OP:  next_state_s = halt ? REQ_OP : CAP_OP;
            CAP_OP:  next_state_s = (op_len_s != 2'd1) ? CAP_LO : ISSUE;
            CAP_LO:  next_state_s = (len_r == 2'd3) ? CAP_HI : ISSUE;
            CAP_HI:  next_state_s = ISSUE;
            ISSUE:   next_state_s = issue.instr_ready ? REQ_OP : ISSUE;
            default: next_state_s = REQ_OP;
         endcase
      end
   end

   // Strobes and valid; everything is quiet while reset is asserted.
   always_comb begin
      pc_increment = 1'b0;
      pc_set       = 1'b0;
      pc_new_count = '0;
      jump_ack     = 1'b0;
      valid_s      = 1'b0;
      if (!reset) begin
         pc_set = 1'b0;
      end else if (jump_req) begin
         pc_set       = 1'b1;
         pc_new_count = jump_target;
         jump_ack     = 1'b1;
      end else begin
         case (state_r)
            REQ_OP:  pc_increment = !halt;
            CAP_OP:  pc_increment = (op_len_s != 2'd1);
            CAP_LO:  pc_increment = (len_r == 2'd3);
            ISSUE:   valid_s      = 1'b1;
            default: valid_s      = 1'b0;
         endcase
      end
   end

   // Instruction field capture; a jump cycle captures nothing.
   always_ff @(posedge clock) begin
      if (!reset) begin
         opcode_r   <= '0;
         operand_r  <= '0;
         len_r      <= 2'd0;
         instr_pc_r <= '0;
      end else if (!jump_req) begin
         case (state_r)
            REQ_OP: begin
               if (!halt) begin
                  instr_pc_r <= pc_count;
               end
            end
            CAP_OP: begin
               opcode_r  <= mem_data;
               operand_r <= '0;
               len_r     <= op_len_s;
            end
            CAP_LO:  operand_r[DATA_W-1:0]        <= mem_data;
            CAP_HI:  operand_r[2*DATA_W-1:DATA_W] <= mem_data;
            default: len_r                        <= len_r;
         endcase
      end
   end

   assign issue.instr_valid = valid_s;
   assign issue.opcode      = opcode_r;
   assign issue.operand     = operand_r;
   assign issue.instr_len   = len_r;
   assign issue.instr_pc    = instr_pc_r;

`ifdef FETCH_PERF_EN
   logic [15:0] instr_count_r;

   // Saturating count of accepted instructions; jumps leave it untouched.
   always_ff @(posedge clock) begin
      if (!reset) begin
         instr_count_r <= 16'd0;
      end else if (valid_s && issue.instr_ready && (instr_count_r != 16'hFFFF)) begin
         instr_count_r <= instr_count_r + 16'd1;
      end
   end

   assign instr_count = instr_count_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: program counter and 1-cycle memory models,
// expected instructions queued up front and compared on each handshake.
module tb_fetch_sequencer;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] opd;
      logic [1:0]  len;
      logic [15:0] pc;
   } exp_t;

   logic        clock;
   logic        reset;
   logic [15:0] pc_count;
   logic        pc_increment;
   logic        pc_set;
   logic [15:0] pc_new_count;
   logic [7:0]  mem_data;
   logic        halt;
   logic        jump_req;
   logic [15:0] jump_target;
   logic        jump_ack;
`ifdef FETCH_PERF_EN
   logic [15:0] instr_count;
`endif

   logic [7:0]  mem [0:65535];
   exp_t        sb[$];
   int          checks_total;
   int          checks_passed;
   int          n;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .pc_count     (pc_count),
      .pc_increment (pc_increment),
      .pc_set       (pc_set),
      .pc_new_count (pc_new_count),
      .mem_data     (mem_data),
      .halt         (halt),
      .jump_req     (jump_req),
      .jump_target  (jump_target),
      .jump_ack     (jump_ack),
`ifdef FETCH_PERF_EN
      .instr_count  (instr_count),
`endif
      .issue        (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Program counter and synchronous byte memory as seen by the sequencer.
   always @(posedge clock) begin
      if (!reset) pc_count <= 16'h0000;
      else if (pc_set) pc_count <= pc_new_count;
      else if (pc_increment) pc_count <= pc_count + 16'h0001;
      mem_data <= mem[pc_count];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   // Handshake scoreboard and jump strobe sanity.
   always @(negedge clock) begin
      exp_t e;
      #2;
      if (reset && bus.instr_valid && bus.instr_ready) begin
         check_val("sb_nonempty", sb.size(), 1 + ((sb.size() > 1) ? sb.size() - 1 : 0));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("opcode", bus.opcode, e.op);
            check_val("operand", bus.operand, e.opd);
            check_val("instr_len", bus.instr_len, e.len);
            check_val("instr_pc", bus.instr_pc, e.pc);
         end
      end
      if (pc_set) begin
         check_val("set_excl_inc", pc_increment, 0);
         check_val("set_ack", jump_ack, 1);
      end
   end

   task automatic wait_valid(input int budget, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
         #1;
      end while (!bus.instr_valid && cnt < budget);
      check_val("valid_seen", bus.instr_valid, 1);
   endtask

   task automatic wait_empty(input int budget);
      int k;
      k = 0;
      do begin
         step();
         #3;
         k++;
      end while (sb.size() != 0 && k < budget);
      check_val("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0000] = 8'h05;
      mem[16'h0001] = 8'h80; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
      mem[16'h0004] = 8'h41; mem[16'h0005] = 8'hAA;
      mem[16'h0006] = 8'h80; mem[16'h0007] = 8'h11; mem[16'h0008] = 8'h22;
      mem[16'h0100] = 8'h00;
      mem[16'h0101] = 8'h7F; mem[16'h0102] = 8'h55;
      mem[16'h0103] = 8'hC3; mem[16'h0104] = 8'h99; mem[16'h0105] = 8'h88;
      mem[16'hFFFF] = 8'h81;

      reset = 1'b0; halt = 1'b0; jump_req = 1'b0; jump_target = 16'h0000;
      bus.instr_ready = 1'b1;
      repeat (3) step();
      #1;
      check_val("rst_valid", bus.instr_valid, 0);
      check_val("rst_inc", pc_increment, 0);
      check_val("rst_set", pc_set, 0);
      check_val("rst_ack", jump_ack, 0);
      check_val("rst_opcode", bus.opcode, 0);
      check_val("rst_operand", bus.operand, 0);
      check_val("rst_len", bus.instr_len, 0);
      check_val("rst_ipc", bus.instr_pc, 0);
      check_val("rst_newpc", pc_new_count, 0);

      // Release: 1-byte then 3-byte instruction.
      sb.push_back('{8'h05, 16'h0000, 2'd1, 16'h0000});
      sb.push_back('{8'h80, 16'h1234, 2'd3, 16'h0001});
      step();
      reset = 1'b1;
      #1;
      check_val("c1_valid", bus.instr_valid, 0);
      check_val("c1_inc", pc_increment, 1);
      step(); #1;
      check_val("c2_valid", bus.instr_valid, 0);
      step(); #1;
      check_val("c3_valid", bus.instr_valid, 1);
      check_val("c3_pc", pc_count, 16'h0001);
      wait_valid(20, n);
      check_val("len3_latency", n, 5);
      check_val("after3_pc", pc_count, 16'h0004);

      // 2-byte instruction held with ready low for 5 cycles.
      sb.push_back('{8'h41, 16'h00AA, 2'd2, 16'h0004});
      step();
      bus.instr_ready = 1'b0;
      wait_valid(20, n);
      check_val("len2_latency", n, 3);
      for (int i = 0; i < 5; i++) begin
         check_val("hold_valid", bus.instr_valid, 1);
         check_val("hold_inc", pc_increment, 0);
         check_val("hold_op", bus.opcode, 8'h41);
         check_val("hold_opd", bus.operand, 16'h00AA);
         check_val("hold_ipc", bus.instr_pc, 16'h0004);
         step(); #1;
      end
      bus.instr_ready = 1'b1;

      // Jump during CAP_LO of a 3-byte fetch at 0x0006.
      step(); #1;
      check_val("pc_before_jump", pc_count, 16'h0006);
      step(); #1;
      check_val("ipc_next", bus.instr_pc, 16'h0006);
      step();
      jump_req = 1'b1; jump_target = 16'h0100;
      #1;
      check_val("jmp_set", pc_set, 1);
      check_val("jmp_inc", pc_increment, 0);
      check_val("jmp_newpc", pc_new_count, 16'h0100);
      check_val("jmp_valid", bus.instr_valid, 0);
      step();
      jump_req = 1'b0;
      #1;
      check_val("post_jmp_set", pc_set, 0);
      check_val("post_jmp_ack", jump_ack, 0);
      check_val("post_jmp_newpc", pc_new_count, 0);
      check_val("post_jmp_pc", pc_count, 16'h0100);
      sb.push_back('{8'h00, 16'h0000, 2'd1, 16'h0100});
      sb.push_back('{8'h7F, 16'h0055, 2'd2, 16'h0101});
      wait_empty(40);

      // Halt at REQ_OP for three cycles.
      step();
      halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("halt_inc", pc_increment, 0);
         check_val("halt_pc", pc_count, 16'h0103);
         step();
      end
      halt = 1'b0;
      #1;
      check_val("resume_inc", pc_increment, 1);

      // Reset during CAP_HI of the 3-byte instruction at 0x0103.
      step(); step(); step();
      reset = 1'b0;
      step(); #1;
      check_val("mid_rst_valid", bus.instr_valid, 0);
      check_val("mid_rst_inc", pc_increment, 0);
      check_val("mid_rst_op", bus.opcode, 0);
      check_val("mid_rst_opd", bus.operand, 0);
      check_val("mid_rst_len", bus.instr_len, 0);
      check_val("mid_rst_ipc", bus.instr_pc, 0);
      check_val("mid_rst_pc", pc_count, 0);
`ifdef FETCH_PERF_EN
      check_val("mid_rst_count", instr_count, 0);
`endif
      sb.push_back('{8'h05, 16'h0000, 2'd1, 16'h0000});
      step();
      reset = 1'b1;
      wait_empty(20);

      // Jump with halt to 0xFFFF, then a 3-byte fetch straddling the wrap.
      step();
      jump_req = 1'b1; jump_target = 16'hFFFF; halt = 1'b1;
      #1;
      check_val("jh_set", pc_set, 1);
      step();
      jump_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_val("jh_inc", pc_increment, 0);
         check_val("jh_pc", pc_count, 16'hFFFF);
         step();
      end
      sb.push_back('{8'h81, 16'h8005, 2'd3, 16'hFFFF});
      halt = 1'b0;
      wait_empty(20);
`ifdef FETCH_PERF_EN
      check_val("perf_count", instr_count, 2);
`endif
      check_val("sb_final", sb.size(), 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that drives the 16-bit loadable program counter and the byte-wide instruction memory. It reads variable-length instructions (1–3 bytes), assembles the opcode and 16-bit operand, and presents them to decode/execute through a valid/ready handshake. It also applies jumps from execute by loading the PC in a single cycle, discarding any partly fetched instruction.

Parameters:
ADDR_W, 16, PC/address width; must match the program counter.
DATA_W, 8, memory data width; opcode width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low; shared with the program counter.
pc_count  in  16  current program-counter value (memory read address).
pc_increment  out  1  PC increment strobe.
pc_set  out  1  PC load strobe; has priority over increment inside the PC.
pc_new_count  out  16  PC load value.
mem_data  in  8  memory read data for the address presented on the previous cycle (fixed 1-cycle latency).
halt  in  1  hold fetch at an instruction boundary.
instr_valid  out  1  assembled instruction is available.
instr_ready  in  1  consumer accepts the instruction.
opcode  out  8  opcode byte.
operand  out  16  operand; the first operand byte goes to [7:0], the second to [15:8]; unused bytes read as 0.
instr_len  out  2  instruction length in bytes (1, 2 or 3).
instr_pc  out  16  address of the opcode byte.
jump_req  in  1  execute requests a jump.
jump_target  in  16  jump destination.
jump_ack  out  1  jump accepted, same cycle as pc_set.

Behaviour:
- Reset (reset=0 at a clock edge): state goes to REQ_OP. opcode, operand, instr_len and instr_pc go to 0. All strobes and instr_valid are 0 during reset. A reset mid-fetch discards the instruction. The PC resets to 0 on the same edge.
- States: REQ_OP, CAP_OP, CAP_LO, CAP_HI, ISSUE.
- REQ_OP:
  - If halt=1, stay in REQ_OP with no strobes.
  - Otherwise capture instr_pc<=pc_count, set pc_increment=1, go to CAP_OP.
- CAP_OP:
  - Capture opcode<=mem_data and clear operand to 0.
  - Length decode from mem_data[7:6]: 00→1, 01→2, 1x→3.
  - If len>1: pc_increment=1, go to CAP_LO. Otherwise go to ISSUE.
- CAP_LO:
  - Capture operand[7:0]<=mem_data.
  - If len=3: pc_increment=1, go to CAP_HI. Otherwise go to ISSUE.
- CAP_HI: capture operand[15:8]<=mem_data, go to ISSUE.
- ISSUE:
  - instr_valid=1. opcode, operand, instr_len and instr_pc are held stable.
  - Handshake when instr_valid and instr_ready are both 1 at the edge; then go to REQ_OP.
  - While instr_ready=0, stay in ISSUE with no PC strobes.
- Latency from REQ_OP to instr_valid: 2, 3 or 4 cycles for 1, 2 or 3 bytes. Back-to-back issue with instr_ready tied to 1: one instruction every len+2 cycles.
- Jump, priority over everything except reset:
  - jump_req=1 in any state: pc_set=1, pc_new_count=jump_target, jump_ack=1, pc_increment=0, instr_valid forced to 0 (no handshake that cycle).
  - Next state is REQ_OP; any partial or pending instruction is dropped.
  - jump_ack is combinational. Execute drops jump_req after ack; a held request reloads the PC every cycle.
  - jump_req with halt=1: the jump is taken, then the sequencer waits in REQ_OP.
- pc_new_count = jump_target when pc_set=1, otherwise 0.
- PC wraps 0xFFFF→0x0000 inside the counter. An instruction straddling the wrap fetches bytes from 0x0000 with no special handling.
- Never assert pc_set and pc_increment in the same cycle.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output port instr_count [15:0].
  - Increments on each handshake and saturates at 0xFFFF.
  - Cleared by reset; not cleared by jumps.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, mem[0]=0x05, instr_ready=1 → instr_valid in the 3rd cycle after release; opcode=0x05, operand=0x0000, instr_len=1, instr_pc=0x0000; pc_count=0x0001.
- mem[0..2]=0x80,0x34,0x12 → opcode=0x80, operand=0x1234, instr_len=3; valid 4 cycles after REQ_OP; next instr_pc=0x0003.
- mem[0..1]=0x41,0xAA with instr_ready=0 for 5 cycles → valid held with fields stable, no PC strobes; the handshake on cycle 6 gives next instr_pc=0x0002.
- jump_req=1, target=0x0100, asserted in CAP_LO of a 3-byte fetch → one-cycle pc_set and jump_ack, no issue of the partial instruction; next instr_pc=0x0100.
- halt=1 for 3 cycles at REQ_OP → pc_increment=0 and pc_count constant; fetch resumes on the cycle halt drops.
- reset=0 during CAP_HI → next cycle all outputs 0, state REQ_OP, first issued instr_pc=0x0000; with FETCH_PERF_EN, instr_count=0.
